// File: rtl/fft_modulus_calc.sv
// fft_modulus_calc
// Squared magnitude (re^2 + im^2) of each FFT output point, written into the
// downstream modulus FIFO. The FFT core cannot be stalled, so whole frames
// are admitted or dropped at their sop, based on FIFO room at that moment.
//
// Ports:
//   clk, tb_rst       clock, asynchronous active-high reset
//   fft_valid         point valid; no backpressure exists
//   fft_sop/fft_eop   first/last point of frame, qualified by fft_valid
//   fft_re/fft_im     signed point components
//   wr_water_level    FIFO fill level, sampled with the sop point
//   wr_full           FIFO full flag (used only for error detection)
//   wr_data           {sop tag, re^2+im^2}
//   wr_en             FIFO write strobe
//   frame_cnt         frames passed completely (wraps)
//   drop_cnt          frames dropped at the gate (wraps)
//   len_err           sticky frame-length / protocol error
//   ovf_err           sticky write-while-full error
//   fsm_state         current frame state (IDLE=0, PASS=1, DROP=2) for debug
//
// Handshake: a point transfers on every cycle fft_valid=1; there is no ready.
// On the write side wr_en=1 is a single-cycle write with no acknowledge.
module fft_modulus_calc #(
    parameter int DATA_W       = 36,
    parameter int FFT_POINTS   = 1024,
    parameter int FIFO_DEPTH_W = 12,
    parameter int SLACK        = 4
) (
    input  logic                      clk,
    input  logic                      tb_rst,
    input  logic                      fft_valid,
    input  logic                      fft_sop,
    input  logic                      fft_eop,
    input  logic signed [DATA_W-1:0]  fft_re,
    input  logic signed [DATA_W-1:0]  fft_im,
    input  logic [FIFO_DEPTH_W:0]     wr_water_level,
    input  logic                      wr_full,
    output logic [2*DATA_W:0]         wr_data,
    output logic                      wr_en,
    output logic [15:0]               frame_cnt,
    output logic [15:0]               drop_cnt,
    output logic                      len_err,
    output logic                      ovf_err,
    output logic [1:0]                fsm_state
);

    // A frame is admitted only if a whole frame plus slack still fits.
    localparam int THR   = 2**FIFO_DEPTH_W - FFT_POINTS - SLACK;
    localparam int IDX_W = $clog2(FFT_POINTS + 1) + 1;
    localparam logic [FIFO_DEPTH_W:0] THR_L  = (FIFO_DEPTH_W+1)'(THR);
    localparam logic [IDX_W-1:0]      LAST_L = IDX_W'(FFT_POINTS);

    typedef enum logic [1:0] {IDLE = 2'd0, PASS = 2'd1, DROP = 2'd2} state_t;

    state_t           state, nxt_state;
    logic [IDX_W-1:0] idx, nxt_idx, idx_inc;
    logic             gate_ok, accept, frame_done, drop_inc, err;

    assign gate_ok   = (wr_water_level <= THR_L);
    assign idx_inc   = idx + 1'b1;
    assign fsm_state = state;

    // Frame admission. A sop always restarts the decision, whatever state we
    // are in; a sop inside a frame is itself a protocol error.
    always_comb begin
        nxt_state  = state;
        nxt_idx    = idx;
        accept     = 1'b0;
        frame_done = 1'b0;
        drop_inc   = 1'b0;
        err        = 1'b0;
        if (fft_valid) begin
            if (fft_sop) begin
                if (state != IDLE) err = 1'b1;
                if (gate_ok) begin
                    accept    = 1'b1;
                    nxt_idx   = IDX_W'(1);
                    nxt_state = PASS;
                    if (fft_eop) begin
                        // Single-point frame.
                        nxt_state = IDLE;
                        nxt_idx   = '0;
                        if (FFT_POINTS == 1) frame_done = 1'b1;
                        else                 err        = 1'b1;
                    end
                end else begin
                    drop_inc  = 1'b1;
                    nxt_idx   = '0;
                    nxt_state = fft_eop ? IDLE : DROP;
                end
            end else begin
                case (state)
                    IDLE: err = 1'b1;
                    PASS: begin
                        accept  = 1'b1;
                        nxt_idx = idx_inc;
                        if (fft_eop) begin
                            nxt_state = IDLE;
                            nxt_idx   = '0;
                            if (idx_inc == LAST_L) frame_done = 1'b1;
                            else                   err        = 1'b1;
                        end
                    end
                    DROP: if (fft_eop) nxt_state = IDLE;
                    default: nxt_state = IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge tb_rst) begin
        if (tb_rst) begin
            state     <= IDLE;
            idx       <= '0;
            frame_cnt <= '0;
            drop_cnt  <= '0;
            len_err   <= 1'b0;
        end else begin
            state <= nxt_state;
            idx   <= nxt_idx;
            if (frame_done) frame_cnt <= frame_cnt + 16'd1;
            if (drop_inc)   drop_cnt  <= drop_cnt + 16'd1;
            if (err)        len_err   <= 1'b1;
        end
    end

    // Three-stage datapath: register inputs, square, sum. Points already
    // accepted always run to completion regardless of the frame state.
    logic                       s1_valid, s1_sop;
    logic signed [DATA_W-1:0]   s1_re, s1_im;
    logic                       s2_valid, s2_sop;
    logic [2*DATA_W-1:0]        s2_sq_re, s2_sq_im;
    logic signed [2*DATA_W-1:0] prod_re, prod_im;

    // Full-width signed squares; always non-negative, so they are held
    // unsigned. Their sum peaks at 2^(2*DATA_W-1) and cannot overflow.
    assign prod_re = s1_re * s1_re;
    assign prod_im = s1_im * s1_im;

    always_ff @(posedge clk or posedge tb_rst) begin
        if (tb_rst) begin
            s1_valid <= 1'b0;
            s1_sop   <= 1'b0;
            s1_re    <= '0;
            s1_im    <= '0;
            s2_valid <= 1'b0;
            s2_sop   <= 1'b0;
            s2_sq_re <= '0;
            s2_sq_im <= '0;
            wr_en    <= 1'b0;
            wr_data  <= '0;
            ovf_err  <= 1'b0;
        end else begin
            s1_valid <= accept;
            s1_sop   <= accept & fft_sop;
            s1_re    <= fft_re;
            s1_im    <= fft_im;
            s2_valid <= s1_valid;
            s2_sop   <= s1_sop;
            s2_sq_re <= prod_re;
            s2_sq_im <= prod_im;
            wr_en    <= s2_valid;
            wr_data  <= {s2_sop, s2_sq_re + s2_sq_im};
            // The FIFO drops a write while full; remember that it happened.
            if (wr_en && wr_full) ovf_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fft_modulus_calc.sv
// Directed testbench for fft_modulus_calc: hand-computed expected write data
// is queued per admitted point and compared as wr_en strobes appear.
module tb_fft_modulus_calc;

    logic        clk;
    logic        tb_rst;
    logic        fft_valid, fft_sop, fft_eop;
    logic [35:0] fft_re, fft_im;
    logic [12:0] wr_water_level;
    logic        wr_full;
    logic [72:0] wr_data;
    logic        wr_en;
    logic [15:0] frame_cnt, drop_cnt;
    logic        len_err, ovf_err;
    logic [1:0]  fsm_state;

    fft_modulus_calc dut (
        .clk            (clk),
        .tb_rst         (tb_rst),
        .fft_valid      (fft_valid),
        .fft_sop        (fft_sop),
        .fft_eop        (fft_eop),
        .fft_re         (fft_re),
        .fft_im         (fft_im),
        .wr_water_level (wr_water_level),
        .wr_full        (wr_full),
        .wr_data        (wr_data),
        .wr_en          (wr_en),
        .frame_cnt      (frame_cnt),
        .drop_cnt       (drop_cnt),
        .len_err        (len_err),
        .ovf_err        (ovf_err),
        .fsm_state      (fsm_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard ----------------
    logic [72:0] exp_q[$];
    int n_checks = 0;
    int n_pass   = 0;
    int n_wr     = 0;
    int first_wr_cyc = -1;
    int sop_cyc  = 0;

    localparam logic [71:0] V25   = 72'd25;
    localparam logic [71:0] V_MIN = 72'h80_0000_0000_0000_0000;  // 2^71
    localparam logic [71:0] V_MAX = 72'h3F_FFFF_FFF0_0000_0001;  // (2^35-1)^2

    task automatic check(input string tag, input logic [72:0] got, input logic [72:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        else
            n_pass++;
    endtask

    always @(negedge clk) begin
        if (wr_en) begin
            n_wr++;
            if (first_wr_cyc < 0) first_wr_cyc = cyc;
            if (exp_q.size() == 0) check("unexpected_wr", 73'd1, 73'd0);
            else check("wr_data", wr_data, exp_q.pop_front());
        end
    end

    // ---------------- drivers ----------------
    task automatic drive(input logic v, input logic s, input logic e,
                         input logic [35:0] re, input logic [35:0] im);
        fft_valid = v;
        fft_sop   = s;
        fft_eop   = e;
        fft_re    = re;
        fft_im    = im;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 36'd0, 36'd0);
    endtask

    // Drives one frame of n points. The level is presented only with the sop;
    // afterwards it is moved to the opposite verdict so a gate that re-samples
    // later would be caught.
    task automatic send_frame(input int n, input logic [12:0] level,
                              input bit admitted, input bit extremes);
        logic [35:0] re, im;
        logic [71:0] ev;
        wr_water_level = level;
        for (int k = 0; k < n; k++) begin
            re = 36'd3;
            im = 36'hF_FFFF_FFFC;  // -4
            ev = V25;
            if (extremes && k == 0) begin
                re = 36'h8_0000_0000;  // -2^35
                im = 36'h8_0000_0000;
                ev = V_MIN;
            end else if (extremes && k == 1) begin
                re = 36'h7_FFFF_FFFF;  // 2^35-1
                im = 36'd0;
                ev = V_MAX;
            end
            if (admitted) exp_q.push_back({(k == 0), ev});
            if (k == 0) sop_cyc = cyc;
            drive(1'b1, (k == 0), (k == n - 1), re, im);
            if (k == 0) wr_water_level = admitted ? 13'd4000 : 13'd0;
        end
        idle(6);
    endtask

    // ---------------- main sequence ----------------
    int wr_base;

    initial begin
        tb_rst = 1'b1;
        fft_valid = 1'b0; fft_sop = 1'b0; fft_eop = 1'b0;
        fft_re = '0; fft_im = '0;
        wr_water_level = '0;
        wr_full = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_wr_en", 73'(wr_en), 73'd0);
        check("rst_wr_data", wr_data, 73'd0);
        check("rst_frame_cnt", 73'(frame_cnt), 73'd0);
        check("rst_drop_cnt", 73'(drop_cnt), 73'd0);
        check("rst_len_err", 73'(len_err), 73'd0);
        check("rst_ovf_err", 73'(ovf_err), 73'd0);
        check("rst_state", 73'(fsm_state), 73'd0);
        tb_rst = 1'b0;

        // Single frame, 3 - 4j everywhere; first sop right after release.
        wr_base = n_wr;
        first_wr_cyc = -1;
        send_frame(1024, 13'd0, 1'b1, 1'b0);
        check("latency", 73'(first_wr_cyc - sop_cyc), 73'd3);
        check("f1_writes", 73'(n_wr - wr_base), 73'd1024);
        check("f1_frame_cnt", 73'(frame_cnt), 73'd1);
        check("f1_len_err", 73'(len_err), 73'd0);
        check("f1_q_empty", 73'(exp_q.size()), 73'd0);

        // Extreme magnitudes in the first two points.
        send_frame(1024, 13'd100, 1'b1, 1'b1);
        check("ext_frame_cnt", 73'(frame_cnt), 73'd2);

        // Gate: one word over the threshold drops, exactly at it passes.
        wr_base = n_wr;
        send_frame(1024, 13'd3069, 1'b0, 1'b0);
        check("drop_writes", 73'(n_wr - wr_base), 73'd0);
        check("drop_cnt", 73'(drop_cnt), 73'd1);
        check("drop_state_idle", 73'(fsm_state), 73'd0);
        check("drop_frame_cnt", 73'(frame_cnt), 73'd2);
        wr_base = n_wr;
        send_frame(1024, 13'd3068, 1'b1, 1'b0);
        check("thr_writes", 73'(n_wr - wr_base), 73'd1024);
        check("thr_frame_cnt", 73'(frame_cnt), 73'd3);

        // Writes while full still strobe and flag overflow.
        check("ovf_before", 73'(ovf_err), 73'd0);
        wr_full = 1'b1;
        wr_base = n_wr;
        send_frame(1024, 13'd0, 1'b1, 1'b0);
        wr_full = 1'b0;
        check("ovf_writes", 73'(n_wr - wr_base), 73'd1024);
        check("ovf_err", 73'(ovf_err), 73'd1);
        check("ovf_len_err", 73'(len_err), 73'd0);

        // Short frame: eop on point 1000.
        send_frame(1000, 13'd0, 1'b1, 1'b0);
        check("short_len_err", 73'(len_err), 73'd1);
        check("short_frame_cnt", 73'(frame_cnt), 73'd4);
        check("short_q_empty", 73'(exp_q.size()), 73'd0);

        // Reset at point 500 of a frame.
        wr_water_level = 13'd0;
        for (int k = 0; k < 500; k++) begin
            exp_q.push_back({(k == 0), V25});
            drive(1'b1, (k == 0), 1'b0, 36'd3, 36'hF_FFFF_FFFC);
        end
        tb_rst = 1'b1;
        exp_q.delete();
        fft_valid = 1'b0;
        #1;
        check("mid_rst_wr_en", 73'(wr_en), 73'd0);
        check("mid_rst_frame_cnt", 73'(frame_cnt), 73'd0);
        check("mid_rst_drop_cnt", 73'(drop_cnt), 73'd0);
        check("mid_rst_len_err", 73'(len_err), 73'd0);
        check("mid_rst_ovf_err", 73'(ovf_err), 73'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        tb_rst = 1'b0;
        wr_base = n_wr;
        send_frame(1024, 13'd0, 1'b1, 1'b0);
        check("post_rst_writes", 73'(n_wr - wr_base), 73'd1024);
        check("post_rst_frame_cnt", 73'(frame_cnt), 73'd1);
        check("post_rst_len_err", 73'(len_err), 73'd0);

        // Stray valid without sop while idle.
        wr_base = n_wr;
        drive(1'b1, 1'b0, 1'b0, 36'd3, 36'd4);
        idle(6);
        check("stray_len_err", 73'(len_err), 73'd1);
        check("stray_writes", 73'(n_wr - wr_base), 73'd0);
        check("stray_frame_cnt", 73'(frame_cnt), 73'd1);
        check("final_q_empty", 73'(exp_q.size()), 73'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
